// File: rtl/onp_pkg.sv
// Shared definitions for the infix-to-RPN converter: character codes,
// controller states and the operator helper functions.
package onp_pkg;

    localparam logic [7:0] CH_LPAR   = 8'h28;
    localparam logic [7:0] CH_RPAR   = 8'h29;
    localparam logic [7:0] CH_MUL    = 8'h2A;
    localparam logic [7:0] CH_ADD    = 8'h2B;
    localparam logic [7:0] CH_SUB    = 8'h2D;
    localparam logic [7:0] CH_DIV    = 8'h2F;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DIG_LO = 8'h30;
    localparam logic [7:0] CH_DIG_HI = 8'h39;

    typedef enum logic [2:0] {
        IDLE,
        TERM,
        POP,
        PUSH,
        FLUSH,
        ERR,
        ERR_END
    } state_t;

    // Binding strength; '(' gets 0 so it never yields to an incoming operator.
    function automatic logic [1:0] prec(input logic [7:0] ch);
        logic [1:0] p;
        p = 2'd0;
        if (ch == CH_ADD || ch == CH_SUB) p = 2'd1;
        if (ch == CH_MUL || ch == CH_DIV) p = 2'd2;
        return p;
    endfunction

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_DIG_LO) && (ch <= CH_DIG_HI);
    endfunction

    function automatic logic is_op(input logic [7:0] ch);
        return (ch == CH_ADD) || (ch == CH_SUB) || (ch == CH_MUL) || (ch == CH_DIV);
    endfunction

    // State that handles a non-digit, non-space character once any open number is closed.
    function automatic state_t dispatch(input logic [7:0] ch);
        state_t s;
        s = ERR;
        if (is_op(ch) || ch == CH_RPAR) s = POP;
        if (ch == CH_LPAR)              s = PUSH;
        if (ch == CH_EQ)                s = FLUSH;
        return s;
    endfunction

endpackage

// File: rtl/onp_shunt_stack.sv
// Operator stack: synchronous LIFO with a combinational view of the top entry.
module op_stack #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] top,
    output logic       empty,
    output logic       full
);
    localparam int CW = $clog2(DEPTH + 1);

    // Sized to a power of two so the count can index it directly.
    logic [7:0]    mem [0:(1 << CW) - 1];
    logic [CW-1:0] count_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign top   = empty ? 8'h00 : mem[count_reg - CW'(1)];

    // Occupancy count; guards make overflow and underflow impossible.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Entry storage, written at the current count on push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count_reg] <= din;
        end
    end

endmodule

// File: rtl/onp_shunt.sv
// Streaming shunting-yard converter: ASCII infix in, space-separated RPN out,
// STB/ACK handshakes on both sides, error recovery up to the next '='.
module onp_shunt
    import onp_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter logic [7:0] ERR_CHAR = 8'h21
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_STB,
    input  logic [7:0] IN_CHAR,
    output logic       IN_ACK,
    output logic       OUT_STB,
    output logic [7:0] OUT_CHAR,
    input  logic       OUT_ACK
);
    state_t     state_reg, state_next;
    logic [7:0] cur_reg, cur_next;           // character being processed
    logic       ack_reg, ack_next;           // IN_ACK pulse; cur_reg is decoded in this cycle
    logic       num_open_reg, num_open_next; // an operand is being emitted
    logic       sub_reg, sub_next;           // second half of a two-character emission
    logic       out_stb_reg, out_stb_next;
    logic [7:0] out_char_reg, out_char_next;

    logic       out_free;
    logic       push, pop, clr;
    logic [7:0] top;
    logic       empty, full;

    op_stack #(.DEPTH(DEPTH)) u_stack (
        .clk   (CLK),
        .srst  (RST),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (cur_reg),
        .top   (top),
        .empty (empty),
        .full  (full)
    );

    // The output register can take a new character if empty or draining this cycle.
    assign out_free = !out_stb_reg || OUT_ACK;

    assign IN_ACK   = ack_reg;
    assign OUT_STB  = out_stb_reg;
    assign OUT_CHAR = out_char_reg;

    // Register all controller state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            cur_reg      <= 8'h00;
            ack_reg      <= 1'b0;
            num_open_reg <= 1'b0;
            sub_reg      <= 1'b0;
            out_stb_reg  <= 1'b0;
            out_char_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            ack_reg      <= ack_next;
            num_open_reg <= num_open_next;
            sub_reg      <= sub_next;
            out_stb_reg  <= out_stb_next;
            out_char_reg <= out_char_next;
        end
    end

    // Next-state, stack control and output-register loading.
    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        ack_next      = 1'b0;
        num_open_next = num_open_reg;
        sub_next      = sub_reg;
        out_stb_next  = out_stb_reg && !OUT_ACK;
        out_char_next = out_char_reg;
        push          = 1'b0;
        pop           = 1'b0;
        clr           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ack_reg) begin
                    // Output register is known free here: nothing loads it on a capture edge.
                    if (cur_reg == CH_SPACE) begin
                        state_next = IDLE;
                    end else if (is_digit(cur_reg)) begin
                        out_stb_next  = 1'b1;
                        out_char_next = cur_reg;
                        num_open_next = 1'b1;
                    end else if (num_open_reg) begin
                        state_next = TERM;
                    end else begin
                        state_next = dispatch(cur_reg);
                    end
                end else if (IN_STB && out_free) begin
                    cur_next = IN_CHAR;
                    ack_next = 1'b1;
                end
            end

            TERM: begin
                if (out_free) begin
                    out_stb_next  = 1'b1;
                    out_char_next = SEP_CHAR;
                    num_open_next = 1'b0;
                    state_next    = dispatch(cur_reg);
                end
            end

            POP: begin
                if (sub_reg) begin
                    if (out_free) begin
                        out_stb_next  = 1'b1;
                        out_char_next = SEP_CHAR;
                        sub_next      = 1'b0;
                    end
                end else if (cur_reg == CH_RPAR) begin
                    if (empty) begin
                        state_next = ERR;
                    end else if (top == CH_LPAR) begin
                        pop        = 1'b1;
                        state_next = IDLE;
                    end else if (out_free) begin
                        out_stb_next  = 1'b1;
                        out_char_next = top;
                        pop           = 1'b1;
                        sub_next      = 1'b1;
                    end
                end else if (!empty && (prec(top) >= prec(cur_reg))) begin
                    if (out_free) begin
                        out_stb_next  = 1'b1;
                        out_char_next = top;
                        pop           = 1'b1;
                        sub_next      = 1'b1;
                    end
                end else begin
                    state_next = PUSH;
                end
            end

            PUSH: begin
                if (full) begin
                    state_next = ERR;
                end else begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end

            FLUSH: begin
                if (sub_reg) begin
                    if (out_free) begin
                        out_stb_next  = 1'b1;
                        out_char_next = SEP_CHAR;
                        sub_next      = 1'b0;
                    end
                end else if (empty) begin
                    if (out_free) begin
                        out_stb_next  = 1'b1;
                        out_char_next = CH_EQ;
                        clr           = 1'b1;
                        state_next    = IDLE;
                    end
                end else if (top == CH_LPAR) begin
                    // '=' is already consumed, so skip the discard phase.
                    state_next = ERR_END;
                end else if (out_free) begin
                    out_stb_next  = 1'b1;
                    out_char_next = top;
                    pop           = 1'b1;
                    sub_next      = 1'b1;
                end
            end

            ERR: begin
                if (ack_reg) begin
                    if (cur_reg == CH_EQ) state_next = ERR_END;
                end else if (IN_STB) begin
                    cur_next = IN_CHAR;
                    ack_next = 1'b1;
                end
            end

            ERR_END: begin
                if (out_free) begin
                    out_stb_next = 1'b1;
                    if (!sub_reg) begin
                        out_char_next = ERR_CHAR;
                        sub_next      = 1'b1;
                    end else begin
                        out_char_next = CH_EQ;
                        sub_next      = 1'b0;
                        clr           = 1'b1;
                        num_open_next = 1'b0;
                        state_next    = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
